if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage plus IF/ID latch; feeds the decode stage directly.
//  - Owns the PC and issues one instruction-memory request at a time over a req/ready handshake.
//  - Absorbs memory wait states, decode stalls and branch/jump redirects.
//  - Presents {pc_plus4, inst, valid} to decode; a bubble is always valid=0, inst=0 (NOP).
// PARAMETERS
//  ADDR_W    32            instruction address width (= `InstAddrWidth)
//  DATA_W    32            instruction word width (= `InstDataWidth)
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk            in   1       single clock; all state updates on posedge
//  rst            in   1       synchronous, active-high reset
//  stall          in   1       decode cannot accept; hold IF/ID latch
//  redirect       in   1       branch/jump taken; one-cycle pulse
//  redirect_pc    in   ADDR_W  new fetch address, valid with redirect
//  imem_req       out  1       fetch request
//  imem_addr      out  ADDR_W  fetch address; stable while imem_req && !imem_ready
//  imem_ready     in   1       response this cycle; imem_rdata valid
//  imem_rdata     in   DATA_W  fetched instruction word
//  id_pc_plus4    out  ADDR_W  latched PC+4 of id_inst
//  id_inst        out  DATA_W  latched instruction (0 when bubble)
//  id_valid       out  1       latch holds a real instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=S_RUN, hold buffer empty, id_valid=0, id_inst=0, id_pc_plus4=0.
//   imem_req is forced to 0 while rst=1; the first request goes out in the first cycle after rst drops.
//  FSM states:
//   S_RUN:  imem_req=1, imem_addr=pc.
//   S_DROP: imem_req=1, imem_addr=pc; an in-flight stale request; the fetch target is in tgt_pc.
//   S_HOLD: imem_req=0; an accepted word waits in the hold buffer.
//  Handshake: a transfer occurs on the edge where imem_req && imem_ready.
//   Zero-wait memory gives 1 instruction/cycle. Address never changes mid-request.
//  Priority per edge: rst > redirect > stall > normal.
//  S_RUN, transfer, no redirect:
//   - !stall: latch <= {pc+4, rdata, 1}; pc <= pc+4.
//   - stall: buffer <= {pc+4, rdata}; pc <= pc+4; go S_HOLD; latch held.
//  S_RUN, no transfer:
//   - !stall: latch <= bubble.
//   - stall: latch held.
//  S_HOLD:
//   - !stall: latch <= buffer (valid=1); buffer emptied; go S_RUN.
//   - stall: everything held.
//  Redirect (overrides stall):
//   - In all states, latch <= bubble and the buffer is emptied.
//   - S_RUN with transfer, or S_HOLD: pc <= redirect_pc; go/stay S_RUN; any returned word is discarded.
//   - S_RUN without transfer: tgt_pc <= redirect_pc; go S_DROP, because the outstanding address must stay stable.
//   - S_DROP: tgt_pc <= redirect_pc; the newest redirect wins.
//  S_DROP, transfer, no redirect: rdata discarded; pc <= tgt_pc; go S_RUN.
//   - Latch <= bubble if !stall, held if stall.
//  Arithmetic: pc+4 is modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0. No alignment check; pc[1:0] pass through.
//  Reset mid-request: the outstanding request is abandoned. Memory must tolerate imem_req dropping during rst.
// STRUCTURE
//  Shared define header: `InstAddrWidth, `InstDataWidth, NOP word (0), FSM state encodings S_RUN/S_DROP/S_HOLD.
//  One sub-module: if_id_reg.
//   - Contents: IF/ID latch {pc_plus4, inst, valid} with load/bubble/hold controls.
//   - Also instantiated later for other pipeline latches.
//  FSM, PC, tgt_pc and hold buffer live in if_fetch.
// TESTING
//  1 Reset then zero-wait memory (ready=1):
//    -> imem_addr 0,4,8,...
//    -> id_inst follows one cycle later with id_pc_plus4 = addr+4; id_valid=1 continuous.
//  2 Memory with 2 wait states:
//    -> imem_addr held 3 cycles; id_valid=0 for 2 cycles, then 1 for 1 cycle; no address skipped.
//  3 stall=1 in the cycle the word at 0x10 returns:
//    -> latch held; imem_req=0 next cycle.
//    -> On stall release, id_inst=word@0x10, id_pc_plus4=0x14; next request is addr 0x14.
//  4 redirect to 0x100 while the request at 0x20 is waiting:
//    -> imem_addr stays 0x20 until ready; that word is dropped (id_valid=0).
//    -> Next request 0x100; id_pc_plus4=0x104.
//  5 redirect and stall together in S_HOLD:
//    -> buffer cleared; id_valid=0; next imem_addr=redirect_pc.
//  6 PC wrap and reset: RESET_PC=0xFFFF_FFFC, then rst pulsed mid-request.
//    -> Second fetch is at 0x0.
//    -> After rst, id_valid=0 and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, the NOP word and the fetch FSM encodings.
// Imported by the fetch stage and by the pipeline latches.
package if_fetch_pkg;
    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;
    localparam logic [INST_DATA_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DROP = 2'd1,
        S_HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus: one request at a time, req/ready handshake.
// A transfer happens on the edge where req && ready.
interface if_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_fetch_if_id_reg.sv
// Generic pipeline latch {pc_plus4, inst, valid}; bubble beats load, otherwise it holds.
// A bubble is always valid=0 with a NOP instruction.
module if_id_reg
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [ADDR_W-1:0] d_pc_plus4,
    input  logic [DATA_W-1:0] d_inst,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] inst,
    output logic              valid
);
    logic [ADDR_W-1:0] pc_plus4_p1;
    logic [DATA_W-1:0] inst_p1;
    logic              vld_p1;

    // IF -> ID stage boundary
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            pc_plus4_p1 <= '0;
            inst_p1     <= DATA_W'(NOP);
            vld_p1      <= 1'b0;
        end else if (load) begin
            pc_plus4_p1 <= d_pc_plus4;
            inst_p1     <= d_inst;
            vld_p1      <= 1'b1;
        end
    end

    assign pc_plus4 = pc_plus4_p1;
    assign inst     = inst_p1;
    assign valid    = vld_p1;
endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one memory request at a time, and feeds
// the IF/ID latch while absorbing wait states, decode stalls and redirects.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    if_fetch_if.master        imem,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, tgt_pc, tgt_n, pc_inc;
    logic [ADDR_W-1:0] buf_pc_plus4;
    logic [DATA_W-1:0] buf_inst;
    logic              buf_we, xfer;
    logic              lat_load, lat_bubble;
    logic [ADDR_W-1:0] lat_pc_plus4;
    logic [DATA_W-1:0] lat_inst;

    assign pc_inc    = pc + ADDR_W'(4);
    assign imem.req  = !rst && (state != S_HOLD);
    assign imem.addr = pc;
    assign xfer      = imem.req && imem.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    // Buffer contents need no reset: they are only meaningful in S_HOLD.
    always_ff @(posedge clk) begin
        tgt_pc <= tgt_n;
        if (buf_we) begin
            buf_pc_plus4 <= pc_inc;
            buf_inst     <= imem.rdata;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        tgt_n        = tgt_pc;
        buf_we       = 1'b0;
        lat_load     = 1'b0;
        lat_bubble   = 1'b0;
        lat_pc_plus4 = pc_inc;
        lat_inst     = imem.rdata;
        if (redirect) begin
            lat_bubble = 1'b1;
            // The outstanding address must stay put until the memory answers.
            if (state == S_HOLD || xfer) begin
                pc_n    = redirect_pc;
                state_n = S_RUN;
            end else begin
                tgt_n   = redirect_pc;
                state_n = S_DROP;
            end
        end else begin
            unique case (state)
                S_RUN: begin
                    if (xfer) begin
                        pc_n = pc_inc;
                        if (stall) begin
                            buf_we  = 1'b1;
                            state_n = S_HOLD;
                        end else begin
                            lat_load = 1'b1;
                        end
                    end else begin
                        lat_bubble = !stall;
                    end
                end
                S_DROP: begin
                    lat_bubble = !stall;
                    if (xfer) begin
                        pc_n    = tgt_pc;
                        state_n = S_RUN;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        lat_load     = 1'b1;
                        lat_pc_plus4 = buf_pc_plus4;
                        lat_inst     = buf_inst;
                        state_n      = S_RUN;
                    end
                end
                default: state_n = S_RUN;
            endcase
        end
    end

    if_id_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (lat_load),
        .bubble     (lat_bubble),
        .d_pc_plus4 (lat_pc_plus4),
        .d_inst     (lat_inst),
        .pc_plus4   (id_pc_plus4),
        .inst       (id_inst),
        .valid      (id_valid)
    );
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a vector table for the main pipeline scenarios and a
// hand-written sequence for PC wrap and mid-request reset on a second instance.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst, stall, redirect, ready;
    logic [31:0] redirect_pc;
    logic [31:0] id_pc_plus4, id_inst;
    logic        id_valid;
    logic        rst_w, ready_w;
    logic [31:0] w_pc_plus4, w_inst;
    logic        w_valid;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    if_fetch_if #(.ADDR_W(32), .DATA_W(32)) m0 ();
    if_fetch_if #(.ADDR_W(32), .DATA_W(32)) m1 ();
    assign m0.ready = ready;
    assign m0.rdata = inst_of(m0.addr);
    assign m1.ready = ready_w;
    assign m1.rdata = inst_of(m1.addr);

    if_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem(m0), .id_pc_plus4(id_pc_plus4), .id_inst(id_inst), .id_valid(id_valid));

    if_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst_w), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem(m1), .id_pc_plus4(w_pc_plus4), .id_inst(w_inst), .id_valid(w_valid));

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc4;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy,
                                input logic req, input logic [31:0] addr, input logic v, input logic [31:0] pc4);
        vec_t r;
        r.st = st; r.rd = rd; r.rpc = rpc; r.rdy = rdy;
        r.req = req; r.addr = addr; r.v = v; r.pc4 = pc4;
        return r;
    endfunction

    vec_t vecs[23];

    initial begin
        // zero-wait fetch
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h00,  1'b1, 32'h04);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h04,  1'b1, 32'h08);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h08,  1'b1, 32'h0C);
        // two wait states
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0C,  1'b0, 32'h00);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0C,  1'b0, 32'h00);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0C,  1'b1, 32'h10);
        // stall while word at 0x10 returns
        vecs[6]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h10);
        vecs[7]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h14,  1'b1, 32'h10);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h14,  1'b1, 32'h14);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  1'b1, 32'h18);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h18,  1'b1, 32'h1C);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1C,  1'b1, 32'h20);
        // redirect to 0x100 while 0x20 is waiting
        vecs[12] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h20,  1'b0, 32'h00);
        vecs[13] = mk(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h20,  1'b0, 32'h00);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h20,  1'b0, 32'h00);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h20,  1'b0, 32'h00);
        vecs[16] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b1, 32'h104);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h108);
        // redirect + stall while holding a buffered word
        vecs[18] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h108);
        vecs[19] = mk(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h10C, 1'b0, 32'h00);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b1, 32'h204);
        // redirect on a completing transfer
        vecs[21] = mk(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h204, 1'b0, 32'h00);
        vecs[22] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 1'b1, 32'h304);

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b0;
        rst_w = 1'b1; ready_w = 1'b0;
        tick();
        tick();
        check("reset_req", 0, {31'h0, m0.req}, 32'h0);
        check("reset_valid", 0, {31'h0, id_valid}, 32'h0);
        check("reset_inst", 0, id_inst, 32'h0);
        check("reset_pc4", 0, id_pc_plus4, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            stall = vecs[i].st; redirect = vecs[i].rd; redirect_pc = vecs[i].rpc; ready = vecs[i].rdy;
            #1;
            check("imem_req", i, {31'h0, m0.req}, {31'h0, vecs[i].req});
            check("imem_addr", i, m0.addr, vecs[i].addr);
            tick();
            check("id_valid", i, {31'h0, id_valid}, {31'h0, vecs[i].v});
            check("id_pc_plus4", i, id_pc_plus4, vecs[i].pc4);
            check("id_inst", i, id_inst, vecs[i].v ? inst_of(vecs[i].pc4 - 32'd4) : 32'h0);
        end
        stall = 1'b0; redirect = 1'b0; ready = 1'b0;

        // PC wrap from 0xFFFF_FFFC, then reset in the middle of a request
        rst_w = 1'b0; ready_w = 1'b1;
        #1;
        check("wrap_addr0", 0, m1.addr, 32'hFFFF_FFFC);
        check("wrap_req0", 0, {31'h0, m1.req}, 32'h1);
        tick();
        check("wrap_pc4", 0, w_pc_plus4, 32'h0);
        check("wrap_inst", 0, w_inst, inst_of(32'hFFFF_FFFC));
        check("wrap_addr1", 1, m1.addr, 32'h0);
        tick();
        check("wrap_pc4b", 1, w_pc_plus4, 32'h4);
        ready_w = 1'b0;
        tick();
        check("wrap_pending_addr", 2, m1.addr, 32'h4);
        rst_w = 1'b1;
        #1;
        check("rst_req_forced", 3, {31'h0, m1.req}, 32'h0);
        tick();
        check("rst_valid", 3, {31'h0, w_valid}, 32'h0);
        check("rst_inst", 3, w_inst, 32'h0);
        rst_w = 1'b0; ready_w = 1'b1;
        #1;
        check("restart_addr", 4, m1.addr, 32'hFFFF_FFFC);
        check("restart_req", 4, {31'h0, m1.req}, 32'h1);
        tick();
        check("restart_pc4", 4, w_pc_plus4, 32'h0);
        check("restart_valid", 4, {31'h0, w_valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
